cpu_mem_reader: RTL
===================

# cpu_mem_reader

Read-side master for the 128×8 CPU packet memory. Software writes a packet (length byte + payload) into the memory. This block is started with the packet's base address. It fetches the length byte, then streams the payload bytes out as a valid/ready byte stream to the UPDI command-frame builder. It drives the memory's port-0 pins and owns the port for the whole transfer.

## Interface
- `DATA_WIDTH`, 8, memory and stream byte width
- `ADDR_WIDTH`, 7, memory address width (128 locations)
- `clk0`  in  1  clock; all flops on rising edge
- `rst0_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse: begin a transfer; ignored while `busy`
- `base_addr`  in  ADDR_WIDTH  address of the length byte; sampled with `start`
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  one-cycle pulse: transfer finished
- `err`  out  1  one-cycle pulse coincident with `done`: bad length byte
- `mem_csb0`  out  1  memory chip select, active low
- `mem_web0`  out  1  memory write enable; tied high (reader never writes)
- `mem_addr0`  out  ADDR_WIDTH  memory address
- `mem_din0`  out  DATA_WIDTH  tied 0
- `mem_dout0`  in  DATA_WIDTH  memory read data
- `frame_data`  out  DATA_WIDTH  payload byte
- `frame_valid`  out  1  `frame_data` valid
- `frame_ready`  in  1  downstream accepts the byte
- `frame_last`  out  1  marks the final payload byte

## Operation
- Reset values:
  - `busy`, `done`, `err`, `frame_valid`, `frame_last` = 0
  - `mem_csb0` = 1
  - `mem_addr0`, `frame_data` = 0
  - FSM in IDLE, FIFO empty
- Memory read contract:
  - A read is issued when `mem_csb0` = 0 during cycle t.
  - The memory registers the request at the end of t and updates `mem_dout0` on the falling edge within t+1.
  - The reader captures `mem_dout0` at the end of t+1.
  - `mem_dout0` holds its value while `mem_csb0` = 1.
- FSM states: IDLE → HDR_REQ → HDR_WAIT → HDR_CAP → STREAM → DONE → IDLE.
  - IDLE, `start` = 1: latch `base_addr`, go to HDR_REQ.
  - HDR_REQ: `mem_csb0` = 0, `mem_addr0` = base.
  - HDR_WAIT: idle cycle.
  - HDR_CAP: latch L = `mem_dout0`.
    - L = 0 or L[7] = 1: go to DONE with `err`.
    - Otherwise: `remaining` = L, `rd_addr` = base + 1, go to STREAM.
  - STREAM:
    - Issue a read in a cycle iff `remaining` > 0 and fifo_count + inflight < 4. Here inflight is the read issued in the previous cycle, if any; a pop in the same cycle is not credited.
    - On each issue: `rd_addr` += 1 (mod 128, so 127 wraps to 0) and `remaining` −= 1.
    - Each captured byte is pushed into a 4-entry FIFO.
    - When the FIFO is non-empty, its head drives `frame_data`/`frame_valid`.
    - `frame_last` = 1 when the head is byte L of the transfer.
    - STREAM exits when the last byte handshakes (`frame_valid` & `frame_ready` with `frame_last`).
  - DONE: `done` = 1 (plus `err` if flagged) for one cycle, `busy` = 0 next cycle, return to IDLE.
- `mem_csb0` is low only in HDR_REQ and on STREAM issue cycles.
- Stream rule: `frame_data` and `frame_last` are stable while `frame_valid` & !`frame_ready`.
- A `start` arriving in the same cycle as `done` is ignored.
- Reset mid-transfer: immediate return to reset values. The downstream consumer discards any partial frame.

## Timing
- `start` at cycle 0: `busy`=1 and `mem_csb0`=0 in cycle 1; L latched at end of cycle 3; first payload read in cycle 4.
- With `frame_ready` held high, the first payload byte is valid in cycle 6. After that, one byte per cycle.
- Last byte handshake in cycle c: `done` in cycle c+1.
- Total transfer time with no backpressure: L + 6 cycles from `start` to `done`.
- Sustained throughput is 1 byte/cycle. Backpressure never overflows the FIFO (guaranteed by the credit rule).

## Structure
- Shared package `updi_pkg`:
  - `CPU_MEM_DEPTH` = 128, `CPU_MEM_AW` = 7
  - `cpu_rd_state_t` enum
  - `MAX_PKT_LEN` = 127
- Sub-module `byte_fifo`: 4×8 synchronous FIFO with push/pop/count and asynchronous active-low reset.
- Top level holds the FSM, address/remaining counters and inflight flag.

## Test plan
- Base 0x10, mem[0x10]=3, mem[0x11..0x13]=A1,B2,C3, `frame_ready`=1:
  - Bytes A1, B2, C3 on cycles 6, 7, 8.
  - `frame_last` set with C3; `done` in cycle 9; `err`=0.
- Base 0x7D, length 4, payload at 0x7E, 0x7F, 0x00, 0x01: addresses wrap correctly; 4 bytes out in order.
- Length byte 0x00, then a separate run with length 0x85:
  - `done` and `err` pulse together in cycle 4.
  - No `frame_valid`; no payload reads.
- Length 10, `frame_ready` toggled randomly (including 5-cycle stalls):
  - Data stable under stall; no byte lost or duplicated.
  - `mem_csb0` never low when fifo_count + inflight = 4.
- `rst0_n` pulled low during STREAM at byte 3 of 8:
  - All outputs return to reset values immediately.
  - A new `start` after release completes normally.
- `start` re-pulsed while `busy`: ignored; the original transfer completes unchanged.

Source files
------------

// File: rtl/updi_pkg.sv
// Shared types and constants for the UPDI CPU packet path.
// The memory reader FSM states and packet-memory geometry live here.
package updi_pkg;

  localparam int CPU_MEM_DEPTH = 128;
  localparam int CPU_MEM_AW    = 7;
  localparam int MAX_PKT_LEN   = 127;
  localparam int RD_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_REQ,
    ST_HDR_WAIT,
    ST_HDR_CAP,
    ST_STREAM,
    ST_DONE
  } cpu_rd_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with occupancy count; storage is flop-based so the
// head is available combinationally as dout.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] data_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign do_push = push && (count_reg != (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign dout    = data_reg[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) data_reg[i] <= '0;
    end else if (do_push) begin
      data_reg[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/cpu_mem_reader.sv
// Read-side master for the CPU packet memory: fetches the length byte at a
// base address, then streams the payload out as a valid/ready byte stream.
module cpu_mem_reader
  import updi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = CPU_MEM_AW
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [DATA_WIDTH-1:0] mem_din0,
  input  logic [DATA_WIDTH-1:0] mem_dout0,
  output logic [DATA_WIDTH-1:0] frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  frame_last
);
  localparam int CW = $clog2(RD_FIFO_DEPTH) + 1;

  cpu_rd_state_t         state_reg, state_next;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [ADDR_WIDTH-1:0] rd_addr_reg;
  logic [ADDR_WIDTH-1:0] remaining_reg;
  logic [ADDR_WIDTH-1:0] len_reg;
  logic [ADDR_WIDTH-1:0] sent_reg;
  logic                  inflight_reg;
  logic                  err_reg;

  logic                  issue;
  logic                  pop;
  logic                  hdr_bad;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  assign mem_web0 = 1'b1;
  assign mem_din0 = '0;

  assign hdr_bad = (mem_dout0 == '0) || (mem_dout0 > DATA_WIDTH'(MAX_PKT_LEN));

  // Credit check: a read issued last cycle already owns a FIFO slot, but a
  // pop this cycle is not counted so the FIFO can never overflow.
  assign issue = (state_reg == ST_STREAM) && (remaining_reg != '0) &&
                 (({1'b0, fifo_count} + (CW+1)'(inflight_reg)) < (CW+1)'(RD_FIFO_DEPTH));

  assign frame_valid = !fifo_empty;
  assign frame_data  = fifo_empty ? '0 : fifo_head;
  assign frame_last  = frame_valid && (sent_reg == len_reg - ADDR_WIDTH'(1));
  assign pop         = frame_valid && frame_ready;

  byte_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RD_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk0),
    .rst_n (rst0_n),
    .push  (inflight_reg),
    .din   (mem_dout0),
    .pop   (pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != ST_IDLE);
    done       = 1'b0;
    err        = 1'b0;
    mem_csb0   = 1'b1;
    mem_addr0  = '0;
    unique case (state_reg)
      ST_IDLE:     if (start) state_next = ST_HDR_REQ;
      ST_HDR_REQ: begin
        mem_csb0   = 1'b0;
        mem_addr0  = base_reg;
        state_next = ST_HDR_WAIT;
      end
      ST_HDR_WAIT: state_next = ST_HDR_CAP;
      ST_HDR_CAP:  state_next = hdr_bad ? ST_DONE : ST_STREAM;
      ST_STREAM: begin
        if (issue) begin
          mem_csb0  = 1'b0;
          mem_addr0 = rd_addr_reg;
        end
        if (pop && frame_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        err        = err_reg;
        state_next = ST_IDLE;
      end
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      base_reg      <= '0;
      rd_addr_reg   <= '0;
      remaining_reg <= '0;
      len_reg       <= '0;
      sent_reg      <= '0;
      inflight_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      inflight_reg <= issue;
      if (state_reg == ST_IDLE && start) base_reg <= base_addr;
      if (state_reg == ST_HDR_CAP) begin
        err_reg       <= hdr_bad;
        len_reg       <= mem_dout0[ADDR_WIDTH-1:0];
        remaining_reg <= mem_dout0[ADDR_WIDTH-1:0];
        rd_addr_reg   <= base_reg + ADDR_WIDTH'(1);
        sent_reg      <= '0;
      end
      if (issue) begin
        rd_addr_reg   <= rd_addr_reg + ADDR_WIDTH'(1);
        remaining_reg <= remaining_reg - ADDR_WIDTH'(1);
      end
      if (pop) sent_reg <= sent_reg + ADDR_WIDTH'(1);
    end
  end

endmodule
